// File: rtl/sccpu_trace_fifo_if.sv
// Word-stream link from the trace FIFO to a host or checker.
// The FIFO side uses the master modport and the sink uses the slave modport.
interface sccpu_trace_fifo_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/sccpu_trace_fifo.sv
// Captures a 4-word commit record (pc, inst, aluout, memout) on every enabled edge.
// Drains the records as a word stream; a record that arrives while the FIFO is full is counted as dropped.
module sccpu_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    en,
  input  logic [31:0]             pc,
  input  logic [31:0]             inst,
  input  logic [31:0]             aluout,
  input  logic [31:0]             memout,
  sccpu_trace_fifo_if.master      strm,
  output logic [AW:0]             count,
  output logic                    full,
  output logic                    empty,
  output logic [15:0]             drop_cnt
);

  logic [127:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [1:0]    word_idx_r;
  logic [15:0]   drop_cnt_r;

  logic          empty_s;
  logic          full_s;
  logic          valid_s;
  logic          last_s;
  logic          xfer_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic [127:0]  head_s;
  logic [31:0]   word_s;

  // Handshake decode; a full FIFO still accepts a record when the head leaves on the same edge.
  always_comb begin
    empty_s = (count_r == {(AW+1){1'b0}});
    full_s  = (count_r == (AW+1)'(DEPTH));
    valid_s = !empty_s;
    last_s  = valid_s && (word_idx_r == 2'd3);
    xfer_s  = valid_s && strm.out_ready;
    pop_s   = xfer_s && last_s;
    push_s  = en && (!full_s || pop_s);
    drop_s  = en && !push_s;
  end

  // Head word select: combinational read of the head record.
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    case (word_idx_r)
      2'd0:    word_s = head_s[31:0];
      2'd1:    word_s = head_s[63:32];
      2'd2:    word_s = head_s[95:64];
      2'd3:    word_s = head_s[127:96];
      default: word_s = 32'd0;
    endcase
    if (valid_s) begin
      strm.out_data = word_s;
    end else begin
      strm.out_data = 32'd0;
    end
    strm.out_valid = valid_s;
    strm.out_last  = last_s;
  end

  // Record storage; not cleared by reset.
  always_ff @(posedge clk) begin
    if (!clr && push_s) begin
      mem_r[wr_ptr_r] <= {memout, aluout, inst, pc};
    end
  end

  // Pointers, occupancy, serializer index and drop counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      word_idx_r <= 2'd0;
      drop_cnt_r <= 16'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      // Index wraps 3 -> 0 exactly when the head is popped.
      if (xfer_s) begin
        word_idx_r <= word_idx_r + 2'd1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  assign count    = count_r;
  assign full     = full_s;
  assign empty    = empty_s;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: doc/sccpu_trace_fifo.md
Name: sccpu_trace_fifo

Overview:
- Downstream consumer of the single-cycle CPU's per-cycle observation buses (pc, inst, aluout, memout).
- Each enabled clock, captures one 4-word commit record into an internal FIFO.
- Drains records as a stream of 32-bit words over a valid/ready interface, to a host link or a bench checker.
- Provides a lossless execution trace under backpressure and counts any records it has to drop.

Parameters:
DEPTH, 16, FIFO capacity in records; power of two, minimum 2.
AW, 4, log2(DEPTH); sets pointer width.

Ports:
clk  input  1  rising-edge clock, shared with the CPU
clr  input  1  synchronous active-high reset
en  input  1  capture enable; when 1, one record is sampled this edge
pc  input  32  CPU program counter
inst  input  32  CPU current instruction
aluout  input  32  CPU ALU result
memout  input  32  CPU data-memory read data
out_data  output  32  current stream word
out_valid  output  1  out_data is valid
out_ready  input  1  sink accepts the word this edge
out_last  output  1  current word is the final word (word 3) of its record
count  output  AW+1  records held, from 0 to DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
drop_cnt  output  16  records discarded because the FIFO was full; saturating

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is clr: synchronous and active-high, sampled only on the rising edge of clk.
  - When clr=1 at an edge: read/write pointers, count, word index and drop_cnt all go to 0.
  - Resulting outputs: out_valid=0, out_last=0, out_data=0, empty=1, full=0.
  - Memory array is not reset.
  - clr has priority over every other event in the same edge; en that edge is ignored.
- Record format: word0=pc, word1=inst, word2=aluout, word3=memout, all sampled at the same edge.
- Push:
  - At an edge with en=1, the record is written at the write pointer if (count<DEPTH) or (pop occurs this edge).
  - Otherwise the record is dropped and drop_cnt increments, saturating at 16'hFFFF.
  - Write latency: a record pushed into an empty FIFO makes out_valid=1 in the cycle immediately after the edge.
- Pop / serializer:
  - A 2-bit word index selects the word within the head record.
  - out_valid = !empty.
  - out_data = selected head word when valid, 0 when empty; it is a combinational read of the head entry.
  - out_last = out_valid && (word index == 3).
  - Transfer = out_valid && out_ready at an edge; the word index then increments.
  - A transfer with out_last=1 pops the head: read pointer advances and the word index returns to 0.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and the word index hold stable.
- Simultaneous events:
  - Push and pop in the same edge: count unchanged.
  - Full with a same-edge pop: the push is accepted and nothing is dropped.
- Pointer wrap: pointers are AW bits and wrap modulo DEPTH; full/empty are derived from count, not from pointer comparison.
- count updates: +1 on push-only, -1 on pop-only, unchanged otherwise.
- Reset mid-record: a partially streamed record is discarded with no further words; out_valid=0 on the next cycle.
- en=0: no capture and no drop counting.

Test Plan:
1. Empty-FIFO push with full-rate drain:
   - Stimulus: clr 1 cycle, then en=1 for one edge with pc=0, inst=32'h3c010000, aluout=0, memout=0; out_ready=1.
   - Required: on the next 4 cycles, out_data = 0, 3c010000, 0, 0; out_last only on the 4th; empty=1 afterwards; count returns to 0.
2. Fill and drop:
   - Stimulus: out_ready=0, en=1 for 20 edges with pc=4*i.
   - Required: count=16, full=1, drop_cnt=4; draining then yields pc words 0x00 through 0x3c in order.
3. Backpressure: with one record queued, drive out_ready = 1,0,0,1,0,1,1 -> out_data and out_last hold stable during every stall; exactly 4 transfers; the words are correct.
4. Full plus simultaneous pop:
   - Stimulus: FIFO full, head at word 3, out_ready=1 and en=1 on the same edge.
   - Required: push accepted, count stays 16, drop_cnt unchanged; the new record appears as the last record in the drain.
5. Reset mid-record: clr asserted after 2 of 4 words are transferred -> next cycle out_valid=0, count=0, drop_cnt=0; a following single push streams cleanly starting from word0.
6. Wrap-around: 40 records through with out_ready=1 and en pulsed every 5th edge -> all pc values are received in order and no drops occur.
